// File: rtl/mod_inverse.sv
// Modular inverse d = e^-1 mod totient via iterative extended Euclid with a
// bit-serial restoring divider (one quotient bit per cycle, MSB first).
module mod_inverse #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] e,
  input  logic [W-1:0] totient,
  output logic [W-1:0] d,
  output logic         busy,
  output logic         done,
  output logic         err
);
  localparam int CW = $clog2(W);

  typedef enum logic [2:0] {IDLE, CHECK, DIV, UPDATE, FIX, DONE} state_t;
  state_t state, state_next;

  logic [W-1:0]          old_r, r, tot, qt, rem;
  logic signed [W+1:0]   old_t, t;
  logic [CW-1:0]         cnt;

  logic [W:0]            trial;
  logic                  fits;
  logic [W-1:0]          diff;
  logic [W+1:0]          prod;
  logic signed [W+1:0]   t_new;
  logic [W-1:0]          d_neg;

  // Restoring division step: shift in the next dividend bit, subtract if it fits.
  assign trial = {rem, old_r[cnt]};
  assign fits  = (trial >= {1'b0, r});
  assign diff  = trial[W-1:0] - r;

  // Only the low W+2 bits of qt*t matter; two's complement wraps identically.
  assign prod  = {2'b00, qt} * t;
  assign t_new = old_t - $signed(prod);
  assign d_neg = old_t[W-1:0] + tot;

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (en) state_next = CHECK;
      CHECK:      state_next = (r == '0) ? FIX : DIV;
      DIV:        if (cnt == '0) state_next = UPDATE;
      UPDATE:     state_next = CHECK;
      FIX:        state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      old_r <= '0;
      r     <= '0;
      tot   <= '0;
      qt    <= '0;
      rem   <= '0;
      old_t <= '0;
      t     <= '0;
      cnt   <= '0;
      d     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE, DONE: begin
          if (en) begin
            old_r <= totient;
            r     <= e;
            tot   <= totient;
            old_t <= '0;
            t     <= {{(W+1){1'b0}}, 1'b1};
            done  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        CHECK: begin
          if (r != '0) begin
            rem <= '0;
            qt  <= '0;
            cnt <= CW'(W-1);
          end
        end
        DIV: begin
          rem <= fits ? diff : trial[W-1:0];
          qt  <= {qt[W-2:0], fits};
          cnt <= cnt - CW'(1);
        end
        UPDATE: begin
          old_r <= r;
          r     <= rem;
          old_t <= t;
          t     <= t_new;
        end
        FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (old_r != W'(1) || tot < W'(2)) begin
            d   <= '0;
            err <= 1'b1;
          end else if (old_t >= 0) begin
            d <= old_t[W-1:0];
          end else begin
            d <= d_neg;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
